// File: rtl/phase_marker_emitter.sv
// phase_marker_emitter: queues phase events and emits encoded `slti x0, x0, code` marker
// words, each optionally followed by filler NOPs, into a valid/ready instruction sink.
module phase_marker_emitter #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          PAD_NOPS   = 2,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_phase,
    input  logic        req_end,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_is_marker,
    output logic        halted,
    output logic        seq_error,
    output logic [15:0] emitted_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT, PAD, HALT} state_t;

    state_t      state;
    logic [3:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [3:0]  pad_cnt, req_code, head;
    logic [6:0]  open_map;
    logic        exit_accepted, cur_exit, empty, full, accept, fire, pop, drained;

    function automatic logic [31:0] encode(input logic [3:0] code);
        return {8'd0, code, 5'd0, 3'b010, 5'd0, 7'h13};
    endfunction

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready = !full && !exit_accepted;
    assign accept    = req_valid && req_ready;
    assign req_code  = (req_phase == 3'd7) ? 4'd14 : {req_phase, req_end};
    assign head      = mem[rd_ptr[AW-1:0]];
    assign fire      = out_valid && out_ready;
    // a marker together with all of its filler has just been consumed
    assign drained   = fire && ((state == EMIT && !cur_exit && PAD_NOPS == 0) ||
                                (state == PAD && pad_cnt == 4'd0));
    assign pop       = !empty && (state == IDLE || drained);
    assign halted    = state == HALT;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end

    always_ff @(posedge clock)
        if (accept) mem[wr_ptr[AW-1:0]] <= req_code;

    // ordering is judged at accept time; offending events are still queued
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            open_map      <= '0;
            seq_error     <= 1'b0;
            exit_accepted <= 1'b0;
        end else if (accept) begin
            if (req_phase == 3'd7) begin
                exit_accepted <= 1'b1;
                if (open_map != '0) seq_error <= 1'b1;
            end else begin
                if (open_map[req_phase] == !req_end) seq_error <= 1'b1;
                open_map[req_phase] <= !req_end;
            end
        end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_inst      <= '0;
            out_is_marker <= 1'b0;
            cur_exit      <= 1'b0;
            pad_cnt       <= '0;
            emitted_count <= '0;
        end else begin
            if (fire && state == EMIT && emitted_count != 16'hFFFF)
                emitted_count <= emitted_count + 16'd1;
            if (pop) begin
                state         <= EMIT;
                out_valid     <= 1'b1;
                out_inst      <= encode(head);
                out_is_marker <= 1'b1;
                cur_exit      <= head == 4'd14;
            end else if (state == EMIT && fire && cur_exit) begin
                state         <= HALT;
                out_valid     <= 1'b0;
                out_is_marker <= 1'b0;
            end else if (state == EMIT && fire && PAD_NOPS > 0) begin
                state         <= PAD;
                out_inst      <= NOP_INST;
                out_is_marker <= 1'b0;
                pad_cnt       <= 4'(PAD_NOPS - 1);
            end else if (state == PAD && fire && pad_cnt != 4'd0) begin
                pad_cnt <= pad_cnt - 4'd1;
            end else if (drained) begin
                state         <= IDLE;
                out_valid     <= 1'b0;
                out_is_marker <= 1'b0;
            end
        end
endmodule

// File: tb/tb_phase_marker_emitter.sv
// tb_phase_marker_emitter: two emitters (PAD_NOPS 0 and 2) share one stimulus stream and
// are checked against a word-stream model plus literal directed expectations.
module tb_phase_marker_emitter;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] EXIT_W = 32'h00e02013;

    logic        clock = 0, reset = 1, req_valid = 0, req_end = 0, out_ready = 0;
    logic [2:0]  req_phase = 0;
    logic        rdy[2], ov[2], om[2], hl[2], se[2];
    logic [31:0] oi[2];
    logic [15:0] ec[2];

    int          errors = 0, checks = 0;
    logic [31:0] expq[2][$];
    logic [31:0] cap[2][$];
    logic        capm[2][$];
    logic [6:0]  open_m[2];
    bit          err_m[2], exit_m[2], halt_m[2];
    int          cnt_m[2], acc_cnt[2], starve[2];
    logic [31:0] mon_w;
    logic [31:0] pad_seq[6] = '{32'h00802013, NOP, NOP, 32'h00902013, NOP, NOP};
    logic        pad_mk[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clock = ~clock;

    phase_marker_emitter #(.FIFO_DEPTH(4), .PAD_NOPS(0), .NOP_INST(NOP)) u0 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_phase(req_phase), .req_end(req_end), .out_valid(ov[0]), .out_ready(out_ready),
        .out_inst(oi[0]), .out_is_marker(om[0]), .halted(hl[0]), .seq_error(se[0]),
        .emitted_count(ec[0]));

    phase_marker_emitter #(.FIFO_DEPTH(4), .PAD_NOPS(2), .NOP_INST(NOP)) u2 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_phase(req_phase), .req_end(req_end), .out_valid(ov[1]), .out_ready(out_ready),
        .out_inst(oi[1]), .out_is_marker(om[1]), .halted(hl[1]), .seq_error(se[1]),
        .emitted_count(ec[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // model: every accepted event appends its marker and filler words to the expected stream
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                expq[i].delete(); cap[i].delete(); capm[i].delete();
                open_m[i] = '0; err_m[i] = 0; exit_m[i] = 0; halt_m[i] = 0;
                cnt_m[i] = 0; acc_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ov[i] && out_ready) begin
                    cap[i].push_back(oi[i]);
                    capm[i].push_back(om[i]);
                    if (expq[i].size() == 0) chk($sformatf("spurious_word[%0d]", i), 32'd0, 32'd1);
                    else begin
                        mon_w = expq[i].pop_front();
                        chk($sformatf("out_inst[%0d]", i), oi[i], mon_w);
                        chk($sformatf("out_is_marker[%0d]", i), 32'(om[i]), 32'(mon_w != NOP));
                        if (mon_w != NOP) begin
                            if (cnt_m[i] < 65535) cnt_m[i]++;
                            if (mon_w == EXIT_W) halt_m[i] = 1;
                        end
                    end
                end
                if (req_valid && rdy[i]) begin
                    acc_cnt[i]++;
                    if (req_phase == 3'd7) begin
                        if (open_m[i] != 0) err_m[i] = 1;
                        exit_m[i] = 1;
                        expq[i].push_back(EXIT_W);
                    end else begin
                        if (open_m[i][req_phase] != req_end) err_m[i] = 1;
                        open_m[i][req_phase] = !req_end;
                        expq[i].push_back(32'h00002013 + (32'(req_phase) << 21) + (32'(req_end) << 20));
                        repeat (i * 2) expq[i].push_back(NOP);
                    end
                end
            end
        end
    end

    always @(negedge clock)
        if (!reset)
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("seq_error[%0d]", i), 32'(se[i]), 32'(err_m[i]));
                chk($sformatf("halted[%0d]", i), 32'(hl[i]), 32'(halt_m[i]));
                chk($sformatf("emitted_count[%0d]", i), 32'(ec[i]), 32'(cnt_m[i]));
                if (exit_m[i]) chk($sformatf("ready_after_exit[%0d]", i), 32'(rdy[i]), 32'd0);
                if (halt_m[i]) chk($sformatf("valid_in_halt[%0d]", i), 32'(ov[i]), 32'd0);
                if (expq[i].size() == 0) chk($sformatf("valid_without_work[%0d]", i), 32'(ov[i]), 32'd0);
                starve[i] = (expq[i].size() != 0 && !ov[i]) ? starve[i] + 1 : 0;
                chk($sformatf("output_starved[%0d]", i), 32'(starve[i] <= 2), 32'd1);
            end

    task automatic send(input logic [2:0] p, input logic e);
        req_valid = 1; req_phase = p; req_end = e;
        @(negedge clock);
        req_valid = 0;
    endtask

    task automatic pulse();
        req_valid = 0; reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 32'(rdy[i]), 32'd1);
            chk("rst_out_valid", 32'(ov[i]), 32'd0);
            chk("rst_out_inst", oi[i], 32'h0);
            chk("rst_out_is_marker", 32'(om[i]), 32'd0);
            chk("rst_halted", 32'(hl[i]), 32'd0);
            chk("rst_seq_error", 32'(se[i]), 32'd0);
            chk("rst_count", 32'(ec[i]), 32'd0);
        end
        reset = 0;
        out_ready = 1;
        repeat (4) @(negedge clock);
        send(3'd2, 1'b0);
        @(negedge clock);
        chk("latency_valid", 32'(ov[0]), 32'd1);
        chk("latency_inst", oi[0], 32'h00402013);
        @(negedge clock);
        chk("single_idle", 32'(ov[0]), 32'd0);
        chk("single_count", 32'(ec[0]), 32'd1);

        pulse();
        out_ready = 1;
        send(3'd4, 1'b0);
        send(3'd4, 1'b1);
        repeat (12) @(negedge clock);
        chk("pad_len", 32'(cap[1].size()), 32'd6);
        for (int k = 0; k < 6 && k < cap[1].size(); k++) begin
            chk($sformatf("pad_word%0d", k), cap[1][k], pad_seq[k]);
            chk($sformatf("pad_marker%0d", k), 32'(capm[1][k]), 32'(pad_mk[k]));
        end

        pulse();
        out_ready = 0;
        send(3'd0, 1'b0); send(3'd0, 1'b1); send(3'd1, 1'b0);
        send(3'd1, 1'b1); send(3'd2, 1'b0); send(3'd2, 1'b1);
        chk("bp_accepted", 32'(acc_cnt[0]), 32'd5);
        chk("bp_ready_low", 32'(rdy[0]), 32'd0);
        chk("bp_valid", 32'(ov[0]), 32'd1);
        repeat (3) @(negedge clock);
        chk("bp_hold_inst", oi[0], 32'h00002013);
        chk("bp_hold_marker", 32'(om[0]), 32'd1);
        out_ready = 1;
        repeat (30) @(negedge clock);
        chk("bp_drained0", 32'(expq[0].size()), 32'd0);
        chk("bp_drained2", 32'(expq[1].size()), 32'd0);
        chk("bp_delivered", 32'(cap[0].size()), 32'd5);
        if (cap[0].size() == 5) chk("bp_last", cap[0][4], 32'h00402013);

        pulse();
        out_ready = 1;
        send(3'd0, 1'b1);
        chk("ord_first_err", 32'(se[0]), 32'd1);
        send(3'd1, 1'b0); send(3'd1, 1'b0); send(3'd7, 1'b0);
        repeat (20) @(negedge clock);
        chk("ord_err_sticky", 32'(se[0]), 32'd1);
        chk("ord_count0", 32'(ec[0]), 32'd4);
        chk("ord_count2", 32'(ec[1]), 32'd4);
        chk("ord_halted", 32'(hl[0]), 32'd1);

        pulse();
        send(3'd0, 1'b0); send(3'd0, 1'b1); send(3'd7, 1'b0);
        req_valid = 1; req_phase = 3'd6; req_end = 0;
        repeat (25) @(negedge clock);
        req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            chk("exit_halted", 32'(hl[i]), 32'd1);
            chk("exit_count", 32'(ec[i]), 32'd3);
            chk("exit_valid", 32'(ov[i]), 32'd0);
            chk("exit_ready", 32'(rdy[i]), 32'd0);
            chk("exit_accepts", 32'(acc_cnt[i]), 32'd3);
        end
        chk("exit_len", 32'(cap[1].size()), 32'd7);
        if (cap[1].size() == 7) chk("exit_word", cap[1][6], EXIT_W);

        pulse();
        out_ready = 1;
        send(3'd3, 1'b0); send(3'd3, 1'b1); send(3'd5, 1'b0); send(3'd5, 1'b1);
        for (n = 0; n < 20 && !(ov[1] && !om[1]); n++) @(negedge clock);
        chk("mid_reach_pad", 32'(n < 20), 32'd1);
        reset = 1;
        #1;
        chk("mid_valid", 32'(ov[1]), 32'd0);
        chk("mid_inst", oi[1], 32'h0);
        chk("mid_marker", 32'(om[1]), 32'd0);
        chk("mid_ready", 32'(rdy[1]), 32'd1);
        chk("mid_count", 32'(ec[1]), 32'd0);
        chk("mid_seq_error", 32'(se[1]), 32'd0);
        @(negedge clock);
        reset = 0;
        repeat (8) begin
            @(negedge clock);
            chk("mid_no_stale", 32'(ov[1]), 32'd0);
        end
        chk("mid_nothing_out", 32'(cap[1].size()), 32'd0);

        for (int ep = 0; ep < 8; ep++) begin
            pulse();
            repeat (400) begin
                @(negedge clock);
                req_valid = 1'($urandom % 2);
                req_phase = ($urandom % 100 < 3) ? 3'd7 : 3'($urandom % 7);
                req_end   = 1'($urandom % 2);
                out_ready = ($urandom % 100) < ((ep % 2) ? 90 : 30);
            end
            @(negedge clock);
            req_valid = 0;
            out_ready = 1;
            repeat (60) @(negedge clock);
            for (int i = 0; i < 2; i++) chk($sformatf("rand_drain[%0d]", i), 32'(expq[i].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
